// File: rtl/resource_arbiter.sv
// Two-requester round-robin front end for a pipelined resource; an in-order tag FIFO routes results back.
// Optional per-requester grant statistics are enabled with `define RESOURCE_ARBITER_STATS_EN.
module resource_arbiter #(
   parameter int DATA_W    = 32,
   parameter int TAG_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              in_valid,
   output logic [DATA_W-1:0] resource_input,
   input  logic              out_valid,
   input  logic [DATA_W-1:0] resource_output,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              err_orphan,
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1
);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(TAG_DEPTH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   tag_cnt;
   logic             tag_mem [TAG_DEPTH];
   logic             last_grant;   // 1 when requester 1 won the most recent handshake
   logic             can_issue, grant1, accept, pop, pop_tag;

   // A pop in this cycle frees a slot only from the next cycle on.
   always_comb begin
      can_issue  = !reset && !stall && (tag_cnt < FULL_CNT);
      grant1     = req1_valid && (!req0_valid || !last_grant);
      accept     = can_issue && (req0_valid || req1_valid);
      req0_ready = accept && !grant1;
      req1_ready = accept && grant1;
      pop        = out_valid && (tag_cnt != '0);
      pop_tag    = tag_mem[rd_ptr];
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         tag_cnt        <= '0;
         last_grant     <= 1'b1;
         in_valid       <= 1'b0;
         resource_input <= '0;
         rsp0_valid     <= 1'b0;
         rsp0_data      <= '0;
         rsp1_valid     <= 1'b0;
         rsp1_data      <= '0;
         err_orphan     <= 1'b0;
      end else begin
         in_valid <= accept;
         if (accept) begin
            resource_input <= grant1 ? req1_data : req0_data;
            last_grant     <= grant1;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({accept, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: tag_cnt <= tag_cnt;
         endcase
         rsp0_valid <= pop && !pop_tag;
         rsp1_valid <= pop && pop_tag;
         if (pop && !pop_tag) rsp0_data <= resource_output;
         if (pop && pop_tag)  rsp1_data <= resource_output;
         if (out_valid && !pop) err_orphan <= 1'b1;
      end
   end

   // NOTE: tag storage has no reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr] <= grant1;
   end

`ifdef RESOURCE_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (req0_ready && req0_valid && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (req1_ready && req1_valid && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`else
   assign grant_cnt0 = '0;
   assign grant_cnt1 = '0;
`endif

endmodule

// File: doc/resource_arbiter.md
RESOURCE_ARBITER -- requirements
Module: resource_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of request, resource and response data.
REQ-002 SHALL have parameter TAG_DEPTH, default 4, meaning the number of in-flight tag FIFO entries (power of two, at least 2).
REQ-003 SHALL have ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  global stall; no new issue while high
- req0_valid  input  1  requester 0 has data
- req0_data  input  DATA_W  requester 0 operand
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid, req1_data, req1_ready  same as requester 0, for requester 1
- in_valid  output  1  to resource: operand valid
- resource_input  output  DATA_W  to resource: operand
- out_valid  input  1  from resource: result valid
- resource_output  input  DATA_W  from resource: result
- rsp0_valid  output  1  one-cycle result pulse for requester 0
- rsp0_data  output  DATA_W  result for requester 0
- rsp1_valid, rsp1_data  same as rsp0, for requester 1
- err_orphan  output  1  sticky; result arrived with no tag outstanding
- grant_cnt0, grant_cnt1  output  16  per-requester grant counts (see Configuration)

Function
REQ-004 SHALL set can_issue = !stall && (tag count < TAG_DEPTH); a pop in the same cycle does not raise can_issue.
REQ-005 SHALL arbitrate combinationally; at most one of req0_ready/req1_ready high; readyK=1 only when can_issue and reqK_valid.
REQ-006 SHALL use round-robin: one requester valid -> grant it; both valid -> grant the one not granted last; after reset requester 0 has priority.
REQ-007 SHALL update the last-grant pointer only on an accepted handshake (valid && ready).
REQ-008 SHALL, on acceptance in cycle N, drive in_valid=1 and resource_input=accepted data in cycle N+1 (registered); otherwise in_valid=0 and resource_input holds its value.
REQ-009 SHALL push the granted requester ID (1 bit) into the tag FIFO in the acceptance cycle.
REQ-010 SHALL, on out_valid=1 with FIFO non-empty, pop the oldest tag and in the next cycle pulse rspT_valid=1 with rspT_data=resource_output, where T is the popped tag.
REQ-011 SHALL pulse rsp valids for exactly one cycle; rsp data holds between pulses; responses have no backpressure.
REQ-012 SHALL leave tag count unchanged on simultaneous push and pop, and wrap read/write pointers modulo TAG_DEPTH.
REQ-013 SHALL keep popping and returning results while stall=1; stall only blocks new issue.
REQ-014 SHALL, on out_valid=1 with FIFO empty, set err_orphan=1 (until reset), drop the result, assert no rsp valid and leave the FIFO untouched.
REQ-015 SHALL preserve result order per requester and globally, matching issue order.

Reset
REQ-016 SHALL, when reset=1 at a rising edge, clear: in_valid, resource_input, rsp0/1_valid, rsp0/1_data, err_orphan, grant counters, FIFO pointers and count; set the last-grant pointer so that requester 0 wins the next tie.
REQ-017 SHALL hold req0_ready and req1_ready at 0 while reset=1.
REQ-018 SHALL discard in-flight tags on reset mid-operation; later results with no tag outstanding raise err_orphan.

Configuration
REQ-019 SHALL, with macro RESOURCE_ARBITER_STATS_EN defined, increment grant_cntK by 1 on each accepted requester-K handshake, saturating at 16'hFFFF.
REQ-020 SHALL, without RESOURCE_ARBITER_STATS_EN, keep grant_cnt0 and grant_cnt1 tied to 0 with no counter logic.

Verification
REQ-021 SHALL cover single issue: req0 with data 5 in cycle 0, resource output 10 in cycle 2 -> in_valid in cycle 1, then rsp0_valid=1 with rsp0_data=10 in cycle 3, rsp1_valid=0 throughout.
REQ-022 SHALL cover contention: both requesters valid for 4 cycles -> grants 0,1,0,1; with STATS_EN, grant_cnt0=2 and grant_cnt1=2.
REQ-023 SHALL cover full FIFO: resource stalled with TAG_DEPTH=4 -> 4 acceptances, then both readys 0; one out_valid -> exactly one further acceptance.
REQ-024 SHALL cover stall: stall=1 with 2 tags outstanding -> no readys, both results still return in order to their requesters.
REQ-025 SHALL cover orphan: out_valid with empty FIFO -> err_orphan=1, no rsp pulse; reset clears err_orphan.
REQ-026 SHALL cover saturation (STATS_EN): 65,540 requester-0 grants -> grant_cnt0=16'hFFFF.
